uart_boot_loader: RTL and testbench

- Controller that sequences a program download from the UART byte receiver into the 32x8 instruction memory.
- Owns the memory write port and the address mux between loader and CPU PC.
- Holds the CPU while a download is in progress and validates length, framing and checksum.
- Sits between the UART receiver, the instruction memory and the CPU control unit.

---
 rtl/uart_boot_loader.sv | 149 ++++++++++++++
 tb/tb_uart_boot_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// Sequences a UART program download into the instruction memory: a length byte,
// then data bytes, then a checksum byte. The CPU is held until the download is verified.
module uart_boot_loader #(
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned TIMEOUT = 104150
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Load,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              rx_fe,
   input  logic [ADDR_W-1:0] PC,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [2:0]        err_code,
   output logic [5:0]        byte_count
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_W = 6;

   localparam logic [2:0] ERR_NONE    = 3'b000;
   localparam logic [2:0] ERR_FRAME   = 3'b001;
   localparam logic [2:0] ERR_LENGTH  = 3'b010;
   localparam logic [2:0] ERR_CSUM    = 3'b011;
   localparam logic [2:0] ERR_TIMEOUT = 3'b100;

   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

   state_t            state;
   logic              load_q;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        sum;
   logic [CNT_W-1:0]  len;
   logic [TMR_W-1:0]  timer;

   logic start_c;
   logic active_c;

   assign start_c  = Load & ~load_q;
   assign active_c = (state == LEN) || (state == DATA) || (state == CSUM);

   // The loader owns the address only during its one-cycle write pulse.
   assign mem_addr = mem_we ? wr_addr : PC;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         load_q     <= 1'b0;
         ptr        <= '0;
         wr_addr    <= '0;
         sum        <= '0;
         len        <= '0;
         timer      <= '0;
         mem_we     <= 1'b0;
         mem_wdata  <= '0;
         cpu_hold   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         err_code   <= ERR_NONE;
         byte_count <= '0;
      end else begin
         load_q <= Load;
         mem_we <= 1'b0;
         if (start_c) begin
            // A new request always wins, discarding any byte arriving with it.
            state      <= LEN;
            ptr        <= '0;
            sum        <= '0;
            len        <= '0;
            timer      <= '0;
            byte_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            cpu_hold   <= 1'b1;
            busy       <= 1'b1;
         end else if (active_c) begin
            if (rx_valid && rx_fe) begin
               state    <= ERR;
               error    <= 1'b1;
               busy     <= 1'b0;
               cpu_hold <= 1'b1;
               err_code <= ERR_FRAME;
            end else if (rx_valid) begin
               timer <= '0;
               case (state)
                  LEN: begin
                     if (rx_data == 8'd0 || rx_data > 8'(DEPTH)) begin
                        state    <= ERR;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b1;
                        err_code <= ERR_LENGTH;
                     end else begin
                        len   <= CNT_W'(rx_data);
                        state <= DATA;
                     end
                  end
                  DATA: begin
                     mem_we     <= 1'b1;
                     wr_addr    <= ptr;
                     mem_wdata  <= rx_data;
                     ptr        <= ptr + ADDR_W'(1);
                     byte_count <= byte_count + CNT_W'(1);
                     sum        <= sum + rx_data;
                     if (byte_count + CNT_W'(1) == len) begin
                        state <= CSUM;
                     end
                  end
                  CSUM: begin
                     if (rx_data == sum) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                     end else begin
                        state    <= ERR;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b1;
                        err_code <= ERR_CSUM;
                     end
                  end
                  default: ;
               endcase
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
               state    <= ERR;
               error    <= 1'b1;
               busy     <= 1'b0;
               cpu_hold <= 1'b1;
               err_code <= ERR_TIMEOUT;
            end else begin
               timer <= timer + TMR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: a table of whole downloads plus hand-written corner sequences;
// expected memory writes are queued when bytes are driven and matched as mem_we appears.
module tb_uart_boot_loader;

   localparam int unsigned TO = 64;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Load;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_fe;
   logic [4:0] PC;
   logic       mem_we;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic       error;
   logic [2:0] err_code;
   logic [5:0] byte_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t exp_q[$];

   typedef struct {
      logic [4:0][7:0] b;
      int              n;
      int              fe_idx;
      logic            exp_done;
      logic [2:0]      exp_code;
      logic [5:0]      exp_count;
   } vec_t;

   uart_boot_loader #(.DEPTH(32), .ADDR_W(5), .TIMEOUT(TO)) dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_fe(rx_fe), .PC(PC), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .err_code(err_code),
      .byte_count(byte_count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every write pulse must match the oldest queued expectation.
   always @(negedge Clk) begin
      if (Reset === 1'b1 && mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(w.addr));
            check("wr_data", 32'(mem_wdata), 32'(w.data));
         end
      end
   end

   function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, input int n, input int fe,
                               input logic d, input logic [2:0] c, input logic [5:0] cnt);
      vec_t v;
      v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
      v.n = n; v.fe_idx = fe; v.exp_done = d; v.exp_code = c; v.exp_count = cnt;
      return v;
   endfunction

   // Called on a falling edge; holds the byte across one rising edge, returns on the next falling edge.
   task automatic send(input logic [7:0] d, input logic fe, input bit exp_wr);
      rx_valid = 1'b1;
      rx_data  = d;
      rx_fe    = fe;
      @(negedge Clk);
      rx_valid = 1'b0;
      rx_fe    = 1'b0;
      check("wr_latency", 32'(mem_we), 32'(exp_wr));
   endtask

   task automatic push(input int a, input logic [7:0] d);
      wr_t w;
      w.addr = 5'(a);
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic start_load();
      Load = 1'b0;
      @(negedge Clk);
      Load = 1'b1;
      @(negedge Clk);
      check("start_busy", 32'(busy), 32'd1);
      check("start_hold", 32'(cpu_hold), 32'd1);
      check("start_error", 32'(error), 32'd0);
      check("start_code", 32'(err_code), 32'd0);
   endtask

   vec_t vecs [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] len;
      logic [7:0] s;
      logic [7:0] d;
      bit         fe_seen;
      bit         wr;
      int         c;

      vecs[0] = mk(8'h03, 8'h45, 8'h35, 8'h00, 8'h7A, 5, -1, 1'b1, 3'b000, 6'd3);
      vecs[1] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, -1, 1'b0, 3'b010, 6'd0);
      vecs[2] = mk(8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 1, -1, 1'b0, 3'b010, 6'd0);
      vecs[3] = mk(8'h02, 8'h10, 8'h20, 8'h31, 8'h00, 4, -1, 1'b0, 3'b011, 6'd2);
      vecs[4] = mk(8'h02, 8'h10, 8'h20, 8'h30, 8'h00, 4, -1, 1'b1, 3'b000, 6'd2);
      vecs[5] = mk(8'h03, 8'hAA, 8'hBB, 8'h00, 8'h00, 3,  2, 1'b0, 3'b001, 6'd1);

      Reset = 1'b0; Load = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_fe = 1'b0; PC = 5'd9;
      repeat (2) @(negedge Clk);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_code", 32'(err_code), 32'd0);
      check("rst_count", 32'(byte_count), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd9);
      Reset = 1'b1;
      @(negedge Clk);

      // Bytes arriving while idle must be ignored.
      send(8'h42, 1'b0, 1'b0);
      check("idle_count", 32'(byte_count), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      for (int v = 0; v < 6; v++) begin
         start_load();
         len = vecs[v].b[0];
         fe_seen = 0;
         for (int i = 0; i < vecs[v].n; i++) begin
            wr = (i >= 1) && (i <= int'(len)) && (len != 8'd0) && (len <= 8'd32)
                 && !fe_seen && (vecs[v].fe_idx != i);
            if (vecs[v].fe_idx == i) fe_seen = 1;
            if (wr) push(i - 1, vecs[v].b[i]);
            send(vecs[v].b[i], 1'(vecs[v].fe_idx == i), wr);
         end
         check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
         check($sformatf("v%0d_error", v), 32'(error), 32'(!vecs[v].exp_done));
         check($sformatf("v%0d_code", v), 32'(err_code), 32'(vecs[v].exp_code));
         check($sformatf("v%0d_count", v), 32'(byte_count), 32'(vecs[v].exp_count));
         check($sformatf("v%0d_hold", v), 32'(cpu_hold), 32'(!vecs[v].exp_done));
         check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      end

      // Timeout after the length byte, then recovery by a fresh Load edge.
      start_load();
      send(8'h02, 1'b0, 1'b0);
      c = 0;
      while (error !== 1'b1 && c < int'(TO) + 10) begin
         @(negedge Clk);
         c++;
      end
      check("to_error", 32'(error), 32'd1);
      check("to_cycles", 32'(c), 32'(TO));
      check("to_code", 32'(err_code), 32'b100);
      check("to_hold", 32'(cpu_hold), 32'd1);
      start_load();

      // Load edge coinciding with a data byte: restart wins, the byte is dropped.
      send(8'h03, 1'b0, 1'b0);
      push(0, 8'h11);
      send(8'h11, 1'b0, 1'b1);
      Load = 1'b0;
      @(negedge Clk);
      Load = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
      @(negedge Clk);
      rx_valid = 1'b0;
      check("restart_no_write", 32'(mem_we), 32'd0);
      check("restart_count", 32'(byte_count), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);
      send(8'h01, 1'b0, 1'b0);
      push(0, 8'h77);
      send(8'h77, 1'b0, 1'b1);
      send(8'h77, 1'b0, 1'b0);
      check("restart_done", 32'(done), 32'd1);
      check("restart_count2", 32'(byte_count), 32'd1);

      // Maximum length: all 32 locations, checksum from the bench's own running sum.
      start_load();
      send(8'h20, 1'b0, 1'b0);
      s = 8'h00;
      for (int i = 0; i < 32; i++) begin
         d = 8'(i * 7 + 3);
         s = s + d;
         push(i, d);
         send(d, 1'b0, 1'b1);
      end
      send(s, 1'b0, 1'b0);
      check("max_done", 32'(done), 32'd1);
      check("max_count", 32'(byte_count), 32'd32);

      // Reset asserted while a write pulse is on the bus.
      start_load();
      send(8'h02, 1'b0, 1'b0);
      rx_valid = 1'b1; rx_data = 8'h99;
      @(posedge Clk);
      #1;
      rx_valid = 1'b0;
      check("mid_we_high", 32'(mem_we), 32'd1);
      check("mid_addr", 32'(mem_addr), 32'd0);
      Reset = 1'b0; Load = 1'b0;
      #1;
      check("mid_we_low", 32'(mem_we), 32'd0);
      check("mid_wdata", 32'(mem_wdata), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_hold", 32'(cpu_hold), 32'd0);
      check("mid_count", 32'(byte_count), 32'd0);
      check("mid_addr_pc", 32'(mem_addr), 32'(PC));
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);

      // Idle address sweep: the PC reaches memory unchanged.
      for (int p = 0; p < 32; p++) begin
         PC = 5'(p);
         @(negedge Clk);
         check("pc_sweep", 32'(mem_addr), 32'(p));
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
